// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NUM_REQ requesters; round-robin by default,
// fixed priority (lowest index wins) when BRAM_ARB_FIXED_PRI_EN is defined.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ-1:0]              i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic [NUM_REQ-1:0]              o_rsp_valid,
    output logic [DATA_WIDTH-1:0]           o_rsp_data,
    output logic                            o_bram_ena,
    output logic                            o_bram_we,
    output logic [ADDR_WIDTH-1:0]           o_bram_addr,
    output logic [DATA_WIDTH-1:0]           o_bram_din,
    input  logic [DATA_WIDTH-1:0]           i_bram_dout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   gnt_idx_p0;
    logic               gnt_any_p0;
    logic               gnt_fire_p0;
    logic [NUM_REQ-1:0] gnt_p0;
    logic               vld_p1;
    logic [NUM_REQ-1:0] rsp_owner_p1;

`ifdef BRAM_ARB_FIXED_PRI_EN
    // Descending scan so the lowest valid index is the last one written.
    always_comb begin
        gnt_idx_p0 = '0;
        gnt_any_p0 = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                gnt_idx_p0 = PTR_W'(i);
                gnt_any_p0 = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cand_p0;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Descending offset scan: the smallest offset from rr_ptr wins.
    always_comb begin
        gnt_idx_p0 = '0;
        gnt_any_p0 = 1'b0;
        cand_p0    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_p0 = wrap_add(rr_ptr, i);
            if (i_req_valid[cand_p0]) begin
                gnt_idx_p0 = cand_p0;
                gnt_any_p0 = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            rr_ptr <= '0;
        else if (gnt_fire_p0)
            rr_ptr <= wrap_add(gnt_idx_p0, 1);
    end
`endif

    assign gnt_fire_p0 = gnt_any_p0 & ~RST;
    assign gnt_p0      = gnt_fire_p0 ? (NUM_REQ'(1) << gnt_idx_p0) : '0;
    assign o_req_ready = gnt_p0;
    assign o_bram_ena  = gnt_fire_p0;
    assign o_bram_we   = gnt_fire_p0 & i_req_we[gnt_idx_p0];

    always_comb begin
        o_bram_addr = '0;
        o_bram_din  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_p0[k]) begin
                o_bram_addr = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                o_bram_din  = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---- stage p0 -> p1: read response tracks the BRAM's one-cycle latency
    always_ff @(posedge CLK) begin
        if (RST)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= gnt_fire_p0 & ~i_req_we[gnt_idx_p0];
    end

    always_ff @(posedge CLK) begin
        rsp_owner_p1 <= gnt_p0;
    end

    // Gating with RST drops a read granted just before reset rose.
    assign o_rsp_valid = (vld_p1 && !RST) ? rsp_owner_p1 : '0;
    assign o_rsp_data  = (vld_p1 && !RST) ? i_bram_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural BRAM behind the port.
module tb_bram_port_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 8;
`ifdef BRAM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                          CLK = 1'b0;
    logic                          RST = 1'b1;
    logic [NUM_REQ-1:0]            i_req_valid = '1;
    logic [NUM_REQ-1:0]            i_req_we = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [NUM_REQ-1:0]            o_rsp_valid;
    logic [DATA_WIDTH-1:0]         o_rsp_data;
    logic                          o_bram_ena;
    logic                          o_bram_we;
    logic [ADDR_WIDTH-1:0]         o_bram_addr;
    logic [DATA_WIDTH-1:0]         o_bram_din;
    logic [DATA_WIDTH-1:0]         i_bram_dout = '0;

    bram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .i_req_valid(i_req_valid), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_bram_ena(o_bram_ena), .o_bram_we(o_bram_we),
        .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din),
        .i_bram_dout(i_bram_dout)
    );

    always #5 CLK = ~CLK;

    logic [DATA_WIDTH-1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    always @(posedge CLK) begin
        if (o_bram_ena) begin
            if (o_bram_we) mem[o_bram_addr] <= o_bram_din;
            else           i_bram_dout <= mem[o_bram_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic rst, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] we);
        @(negedge CLK);
        RST = rst;
        i_req_valid = v;
        i_req_we = we;
        #1;
    endtask

    logic [NUM_REQ-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_REQ-1:0] prev_g;

    initial begin
        // reset with every requester valid
        drive(1'b1, 4'b1111, 4'b0000);
        chk("rst_ready", o_req_ready, 4'b0000);
        chk("rst_ena", o_bram_ena, 1'b0);
        chk("rst_rsp_valid", o_rsp_valid, 4'b0000);
        chk("rst_rsp_data", o_rsp_data, 8'h00);
        drive(1'b1, 4'b1111, 4'b0000);
        chk("rst_ready2", o_req_ready, 4'b0000);

        prev_g = '0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b1111, 4'b0000);
            exp_g = FIXED ? 4'b0001 : rr_seq[i];
            chk($sformatf("post_rst_grant%0d", i), o_req_ready, exp_g);
            chk($sformatf("post_rst_ena%0d", i), o_bram_ena, 1'b1);
            if (i > 0) chk($sformatf("post_rst_rsp%0d", i), o_rsp_valid, prev_g);
            prev_g = exp_g;
        end
        drive(1'b0, 4'b0000, 4'b0000);
        chk("idle_after_rst_rsp", o_rsp_valid, prev_g);
        chk("idle_after_rst_ready", o_req_ready, 4'b0000);

        // requester 2: write 0x5A to 0x07, then read it back
        i_req_addr  = {8'h13, 8'h07, 8'h11, 8'h10};
        i_req_wdata = {8'hD3, 8'h5A, 8'hD1, 8'hD0};
        drive(1'b0, 4'b0100, 4'b0100);
        chk("wr_ready", o_req_ready, 4'b0100);
        chk("wr_ena", o_bram_ena, 1'b1);
        chk("wr_we", o_bram_we, 1'b1);
        chk("wr_addr", o_bram_addr, 8'h07);
        chk("wr_din", o_bram_din, 8'h5A);
        drive(1'b0, 4'b0100, 4'b0000);
        chk("rd_ready", o_req_ready, 4'b0100);
        chk("rd_we", o_bram_we, 1'b0);
        chk("rd_addr", o_bram_addr, 8'h07);
        chk("no_rsp_for_wr", o_rsp_valid, 4'b0000);
        chk("no_rsp_for_wr_data", o_rsp_data, 8'h00);
        drive(1'b0, 4'b0000, 4'b0000);
        chk("rd_rsp_valid", o_rsp_valid, 4'b0100);
        chk("rd_rsp_data", o_rsp_data, 8'h5A);
        drive(1'b0, 4'b0000, 4'b0000);
        chk("rd_rsp_once", o_rsp_valid, 4'b0000);

        // held grant: requester 1 alone for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0010, 4'b0000);
            chk($sformatf("held_ready%0d", i), o_req_ready, 4'b0010);
            chk($sformatf("held_ena%0d", i), o_bram_ena, 1'b1);
            if (i > 0) chk($sformatf("held_rsp%0d", i), o_rsp_valid, 4'b0010);
        end
        drive(1'b0, 4'b1111, 4'b0000);
        chk("held_ptr_probe", o_req_ready, FIXED ? 4'b0001 : 4'b0100);
        drive(1'b0, 4'b1000, 4'b0000);
        chk("only3_ready", o_req_ready, 4'b1000);

        // requesters 0 and 3 both held valid
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'b1001, 4'b0000);
            exp_g = (FIXED || (i % 2 == 0)) ? 4'b0001 : 4'b1000;
            chk($sformatf("starve_grant%0d", i), o_req_ready, exp_g);
        end

        // reset arriving right after a read grant to requester 1
        drive(1'b0, 4'b0010, 4'b0000);
        chk("midrd_grant", o_req_ready, 4'b0010);
        drive(1'b1, 4'b1111, 4'b0000);
        chk("midrd_rst_ready", o_req_ready, 4'b0000);
        chk("midrd_rst_ena", o_bram_ena, 1'b0);
        chk("midrd_rst_rsp", o_rsp_valid, 4'b0000);
        chk("midrd_rst_data", o_rsp_data, 8'h00);
        drive(1'b1, 4'b1111, 4'b0000);
        chk("midrd_rst_ready2", o_req_ready, 4'b0000);
        chk("midrd_rst_rsp2", o_rsp_valid, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        chk("midrd_after_rsp", o_rsp_valid, 4'b0000);
        chk("midrd_after_ena", o_bram_ena, 1'b0);

        // idle keeps the pointer where the last grant left it
        drive(1'b0, 4'b0100, 4'b0100);
        chk("idle_pre_grant", o_req_ready, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000, 4'b0000);
            chk($sformatf("idle_ena%0d", i), o_bram_ena, 1'b0);
            chk($sformatf("idle_we%0d", i), o_bram_we, 1'b0);
            chk($sformatf("idle_ready%0d", i), o_req_ready, 4'b0000);
            chk($sformatf("idle_rsp%0d", i), o_rsp_valid, 4'b0000);
            chk($sformatf("idle_data%0d", i), o_rsp_data, 8'h00);
        end
        drive(1'b0, 4'b1111, 4'b0000);
        chk("idle_ptr_probe", o_req_ready, FIXED ? 4'b0001 : 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
